spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Single-byte SPI master: the initiating end of the team's SPI link, paired with the existing SPI slave.
- Generates sclk, ss and mosi from a system clock and samples miso, in any of the four SPI modes, MSB first.
- A start/busy/done handshake lets a host load one byte and collect the byte the slave shifts back.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles (legal range 1..255)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
mode  input  2  SPI mode: mode[1]=CPOL, mode[0]=CPHA; sampled when start is accepted
start  input  1  request a transfer; accepted only when busy=0
tx_data  input  8  byte to transmit; latched when start is accepted
rx_data  output  8  last byte received; updated in the cycle done=1
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer
sclk  output  1  SPI serial clock to slave
mosi  output  1  master-out data
miso  input  1  master-in data
ss  output  1  slave select, active-low

Behaviour:
- Reset values (clk edge with reset=1): sclk=0, ss=1, mosi=0, busy=0, done=0, rx_data=8'h00, state=IDLE, counters=0.
- Reset overrides everything. Mid-transfer reset aborts immediately: ss=1 and sclk=0 next cycle; no done; rx_data cleared.
- States: IDLE, LEAD (setup), XFER, TRAIL (hold).
- IDLE:
  - ss=1, busy=0, mosi=0.
  - sclk=mode[1], registered each cycle, so idle polarity tracks mode.
  - When start=1: latch tx_data into shift register and mode into cpol/cpha; go to LEAD.
  - Next cycle: ss=0, busy=1.
  - If cpha=0, mosi=tx_data[7] in the same cycle as ss falls.
- LEAD: hold for CLK_DIV cycles with sclk=cpol, then go to XFER.
- XFER:
  - Exactly 16 sclk edges, one every CLK_DIV cycles.
  - Odd edges are leading edges (sclk leaves cpol); even edges are trailing edges.
  - cpha=0: sample miso at each leading edge; present next bit on mosi at each trailing edge, except the 16th.
  - cpha=1: present next bit on mosi at each leading edge (first leading edge drives bit7); sample miso at each trailing edge.
  - "Sample" means the miso value in the clk cycle the edge is generated, shifted into rx shift register LSB (MSB first overall).
  - After the 16th edge sclk=cpol; go to TRAIL.
- TRAIL:
  - Hold CLK_DIV cycles with mosi unchanged (holds bit0).
  - Then ss=1, mosi=0, busy=0, done=1 for one cycle, rx_data=received byte; return to IDLE.
- Timing:
  - ss low for exactly 18*CLK_DIV clk cycles.
  - Start accepted at edge N -> done high in cycle N+1+18*CLK_DIV.
- start while busy=1: ignored, no queuing.
- start during the done cycle (busy=0): accepted; ss rises for one cycle, then falls again.
- tx_data/mode changes while busy: no effect on the current transfer.
- CLK_DIV=1: sclk toggles every clk cycle; all rules above still hold.
- rx_data holds its value until the next done or reset.

Test Plan:
- Mode 00, CLK_DIV=4, tx_data=8'h36, slave model returns 8'hDA -> mosi sampled on sclk rising = 00110110; rx_data=8'hDA at done; ss low exactly 72 cycles; sclk idles 0.
- Repeat for modes 01, 10 and 11 with the same bytes -> each rx_data=8'hDA, and the slave receives 8'h36. Modes 10/11: sclk idles 1. Modes 01/11: mosi changes only on leading edges.
- Back-to-back: start held high with tx 8'hA5 then 8'h5A, CLK_DIV=1 -> two done pulses 19 cycles apart; ss high for exactly 1 cycle between transfers; rx_data matches slave bytes.
- Start pulse at 8th sclk edge of an active transfer, with tx_data changed to 8'hFF -> ignored; mosi stream unaffected; single done.
- Reset asserted for 1 cycle at 10th sclk edge -> next cycle ss=1, sclk=0, busy=0, rx_data=8'h00; no done. A following start of 8'h36 completes normally.
- Mode changed from 00 to 11 mid-transfer -> current transfer finishes in mode 00. In IDLE afterwards, sclk goes to 1 the cycle after the change.

Source files
------------

// File: rtl/spi_master.sv
// Single-byte SPI master, MSB first, all four SPI modes.
// One transfer keeps ss low for 18*CLK_DIV clk cycles. The first CLK_DIV
// cycles are lead time with sclk at its idle level. Then come 16 sclk edges,
// one every CLK_DIV cycles. The last CLK_DIV cycles are trail time. done
// pulses in the cycle ss rises.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;        // clk cycles within the current half-period
  logic [3:0] edge_q, edge_d;      // sclk edges already generated (0..15)
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       ss_q, ss_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cnt_last;

  assign cnt_last = (cnt_q == DIV_LAST);

  // Next-state and output logic; all outputs are registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ss_d   = 1'b1;
        busy_d = 1'b0;
        mosi_d = 1'b0;
        sclk_d = mode[1];
        cnt_d  = 8'd0;
        edge_d = 4'd0;
        if (start) begin
          cpol_d  = mode[1];
          cpha_d  = mode[0];
          // With cpha=0, bit 7 goes out together with ss falling.
          // With cpha=1, bit 7 waits for the first leading edge.
          tx_sh_d = mode[0] ? tx_data : {tx_data[6:0], 1'b0};
          mosi_d  = mode[0] ? 1'b0 : tx_data[7];
          rx_sh_d = 8'd0;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = LEAD;
        end
      end
      LEAD: begin
        if (cnt_last) begin
          cnt_d   = 8'd0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      XFER: begin
        if (cnt_last) begin
          cnt_d  = 8'd0;
          sclk_d = ~sclk_q;
          // An even edge_q means the edge being generated is a leading edge.
          // The sampling edge is the leading edge when cpha=0 and the
          // trailing edge when cpha=1.
          if (edge_q[0] == cpha_q) begin
            rx_sh_d = {rx_sh_q[6:0], miso};
          end else if (edge_q != 4'd15) begin
            mosi_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
          if (edge_q == 4'd15) begin
            edge_d  = 4'd0;
            state_d = TRAIL;
          end else begin
            edge_d = edge_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TRAIL: begin
        if (cnt_last) begin
          cnt_d     = 8'd0;
          ss_d      = 1'b1;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      edge_q    <= 4'd0;
      tx_sh_q   <= 8'd0;
      rx_sh_q   <= 8'd0;
      rx_data_q <= 8'd0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss      = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master. It runs two instances: dut0 with CLK_DIV=4 and dut1
// with CLK_DIV=1. A cycle-offset model predicts every output on every cycle.
// A simple SPI slave per instance returns bytes and records what it received.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_r   [2] = '{1'b1, 1'b1};
  logic       start_r [2] = '{1'b0, 1'b0};
  logic [1:0] mode_r  [2] = '{2'd0, 2'd0};
  logic [7:0] tx_r    [2] = '{8'd0, 8'd0};
  logic [7:0] sb      [2] = '{8'd0, 8'd0};
  logic       miso_r  [2] = '{1'b0, 1'b0};
  logic [7:0] rx_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       sclk_w  [2];
  logic       mosi_w  [2];
  logic       ss_w    [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      spi_master #(.CLK_DIV((gi == 0) ? 4 : 1)) u_dut (
        .clk     (clk),
        .reset   (rst_r[gi]),
        .mode    (mode_r[gi]),
        .start   (start_r[gi]),
        .tx_data (tx_r[gi]),
        .rx_data (rx_w[gi]),
        .busy    (busy_w[gi]),
        .done    (done_w[gi]),
        .sclk    (sclk_w[gi]),
        .mosi    (mosi_w[gi]),
        .miso    (miso_r[gi]),
        .ss      (ss_w[gi])
      );
    end
  endgenerate

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check1(input string name, input int i, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %b, expected %b", name, i, $time, act, exp);
    end
  endtask

  task automatic check8(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %02h, expected %02h", name, i, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int i, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Model state. m_off is the cycle offset since the accepting edge, or -1 when
  // no transfer is active. Offset 18*D is the done cycle.
  int         m_off  [2] = '{-1, -1};
  logic [7:0] m_tx   [2] = '{8'd0, 8'd0};
  logic [7:0] m_sb   [2] = '{8'd0, 8'd0};
  logic [7:0] m_rx   [2] = '{8'd0, 8'd0};
  logic [1:0] m_mode [2] = '{2'd0, 2'd0};
  logic       m_idle [2] = '{1'b0, 1'b0};

  // Model advance: accept a start only when not busy, then count cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int d = div_of(i);
      if (rst_r[i]) begin
        m_off[i]  <= -1;
        m_rx[i]   <= 8'd0;
        m_idle[i] <= 1'b0;
      end else begin
        m_idle[i] <= mode_r[i][1];
        if ((m_off[i] < 0 || m_off[i] == 18 * d) && start_r[i]) begin
          m_off[i]  <= 0;
          m_tx[i]   <= tx_r[i];
          m_mode[i] <= mode_r[i];
          m_sb[i]   <= sb[i];
        end else if (m_off[i] >= 0 && m_off[i] < 18 * d) begin
          m_off[i] <= m_off[i] + 1;
          if (m_off[i] + 1 == 18 * d) m_rx[i] <= m_sb[i];
        end else begin
          m_off[i] <= -1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic int d = div_of(i);
        automatic int off = m_off[i];
        automatic int n = 0;
        automatic int lead = 0;
        automatic logic e_ss = 1'b1;
        automatic logic e_busy = 1'b0;
        automatic logic e_done = 1'b0;
        automatic logic e_sclk = m_idle[i];
        automatic logic e_mosi = 1'b0;
        if (off == 18 * d) begin
          e_done = 1'b1;
          e_sclk = m_mode[i][1];
        end else if (off >= 0) begin
          e_ss   = 1'b0;
          e_busy = 1'b1;
          n = off / d - 1;
          if (n < 0) n = 0;
          if (n > 16) n = 16;
          e_sclk = m_mode[i][1] ^ (n % 2 == 1);
          if (!m_mode[i][0]) begin
            e_mosi = m_tx[i][7 - ((n / 2 > 7) ? 7 : n / 2)];
          end else begin
            lead = (n + 1) / 2;
            e_mosi = (lead == 0) ? 1'b0 : m_tx[i][8 - ((lead > 8) ? 8 : lead)];
          end
        end
        check1("ss", i, ss_w[i], e_ss);
        check1("busy", i, busy_w[i], e_busy);
        check1("done", i, done_w[i], e_done);
        check1("sclk", i, sclk_w[i], e_sclk);
        check1("mosi", i, mosi_w[i], e_mosi);
        check8("rx_data", i, rx_w[i], m_rx[i]);
      end
    end
  end

  // SPI slave: shifts its byte out and collects what the master sends.
  logic       s_prev_ss   [2] = '{1'b1, 1'b1};
  logic       s_prev_sclk [2] = '{1'b0, 1'b0};
  logic [7:0] s_out  [2] = '{8'd0, 8'd0};
  logic [7:0] s_in   [2] = '{8'd0, 8'd0};
  logic [7:0] s_last [2] = '{8'd0, 8'd0};
  logic [1:0] s_mode [2] = '{2'd0, 2'd0};
  int         s_bits [2] = '{0, 0};

  // Slave reacts on the falling clk edge, so miso is settled before the
  // master samples it on the next rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_prev_ss[i] && !ss_w[i]) begin
        s_mode[i] <= m_mode[i];
        s_bits[i] <= 0;
        s_in[i]   <= 8'd0;
        if (!m_mode[i][0]) begin
          miso_r[i] <= m_sb[i][7];
          s_out[i]  <= {m_sb[i][6:0], 1'b0};
        end else begin
          s_out[i] <= m_sb[i];
        end
      end else if (!s_prev_ss[i] && !ss_w[i] && sclk_w[i] != s_prev_sclk[i]) begin
        if ((sclk_w[i] != s_mode[i][1]) != s_mode[i][0]) begin
          s_in[i]   <= {s_in[i][6:0], mosi_w[i]};
          s_bits[i] <= s_bits[i] + 1;
        end else begin
          miso_r[i] <= s_out[i][7];
          s_out[i]  <= {s_out[i][6:0], 1'b0};
        end
      end
      if (!s_prev_ss[i] && ss_w[i] && s_bits[i] == 8) begin
        s_last[i] <= s_in[i];
        check8("slave_rx", i, s_in[i], m_tx[i]);
      end
      s_prev_ss[i]   <= ss_w[i];
      s_prev_sclk[i] <= sclk_w[i];
    end
  end

  // Run-length and done bookkeeping for the literal timing checks.
  int cyc = 0;
  int low_len   [2] = '{0, 0};
  int high_len  [2] = '{0, 0};
  int last_low  [2] = '{0, 0};
  int last_high [2] = '{0, 0};
  int done_cnt  [2] = '{0, 0};
  int done_t    [2] = '{0, 0};
  int prev_done [2] = '{0, 0};

  // Track ss run lengths, done pulse counts and done pulse times.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (ss_w[i] === 1'b0) begin
        low_len[i] <= low_len[i] + 1;
        if (high_len[i] > 0) begin
          last_high[i] <= high_len[i];
          high_len[i]  <= 0;
        end
      end else begin
        high_len[i] <= high_len[i] + 1;
        if (low_len[i] > 0) begin
          last_low[i] <= low_len[i];
          low_len[i]  <= 0;
        end
      end
      if (done_w[i] === 1'b1) begin
        done_cnt[i]  <= done_cnt[i] + 1;
        prev_done[i] <= done_t[i];
        done_t[i]    <= cyc;
      end
    end
  end

  task automatic start_xfer(input int i, input logic [7:0] tx, input logic [1:0] md, input logic [7:0] sbv);
    tx_r[i]    = tx;
    mode_r[i]  = md;
    sb[i]      = sbv;
    start_r[i] = 1'b1;
    @(negedge clk);
    start_r[i] = 1'b0;
  endtask

  // Wait for done (bounded). With noise set, start/tx/mode are scrambled
  // while the transfer is busy; none of that may be accepted.
  task automatic wait_done(input int i, input bit noise);
    automatic int lim = 18 * div_of(i) + 8;
    automatic logic seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(negedge clk);
      if (done_w[i] === 1'b1) begin
        seen = 1'b1;
        start_r[i] = 1'b0;
      end else if (noise && m_off[i] >= 0 && m_off[i] < 18 * div_of(i)) begin
        start_r[i] = ($urandom_range(0, 5) == 0);
        tx_r[i]    = 8'($urandom);
        mode_r[i]  = 2'($urandom);
      end
    end
    check1("done_seen", i, seen, 1'b1);
  endtask

  task automatic wait_edges(input int i, input int n);
    automatic logic prev = sclk_w[i];
    automatic int c = 0;
    for (int k = 0; k < 200 && c < n; k++) begin
      @(negedge clk);
      if (sclk_w[i] !== prev) c++;
      prev = sclk_w[i];
    end
    check_int("sclk_edges", i, c, n);
  endtask

  initial begin
    automatic int dc;
    automatic logic [1:0] md;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check1("reset_ss", i, ss_w[i], 1'b1);
      check1("reset_sclk", i, sclk_w[i], 1'b0);
      check1("reset_busy", i, busy_w[i], 1'b0);
      check8("reset_rx", i, rx_w[i], 8'h00);
    end
    rst_r[0] = 1'b0;
    rst_r[1] = 1'b0;
    @(negedge clk);

    // All four modes with the same bytes on the CLK_DIV=4 instance.
    for (int m = 0; m < 4; m++) begin
      md = 2'(m);
      start_xfer(0, 8'h36, md, 8'hDA);
      wait_done(0, 1'b0);
      check8("rx_at_done", 0, rx_w[0], 8'hDA);
      @(negedge clk);
      check8("slave_got", 0, s_last[0], 8'h36);
      check_int("ss_low_len", 0, last_low[0], 72);
      check1("idle_sclk", 0, sclk_w[0], md[1]);
      $display("mode %0d: tx 36 rx %02h slave %02h ss_low %0d", m, rx_w[0], s_last[0], last_low[0]);
    end

    // Back-to-back on CLK_DIV=1 with start held high.
    mode_r[1] = 2'd0;
    tx_r[1] = 8'hA5;
    sb[1] = 8'h3C;
    start_r[1] = 1'b1;
    @(negedge clk);
    tx_r[1] = 8'h5A;
    sb[1] = 8'hC3;
    for (int k = 0; k < 30 && done_w[1] !== 1'b1; k++) @(negedge clk);
    check8("b2b_rx1", 1, rx_w[1], 8'h3C);
    @(negedge clk);
    start_r[1] = 1'b0;
    check8("b2b_slave1", 1, s_last[1], 8'hA5);
    wait_done(1, 1'b0);
    check8("b2b_rx2", 1, rx_w[1], 8'hC3);
    @(negedge clk);
    check_int("b2b_done_gap", 1, done_t[1] - prev_done[1], 19);
    check_int("b2b_ss_high", 1, last_high[1], 1);
    check_int("b2b_ss_low", 1, last_low[1], 18);
    check8("b2b_slave2", 1, s_last[1], 8'h5A);
    $display("back-to-back: rx %02h gap %0d ss_high %0d", rx_w[1], done_t[1] - prev_done[1], last_high[1]);

    // A start at the 8th sclk edge with new tx_data is ignored.
    dc = done_cnt[0];
    start_xfer(0, 8'h36, 2'd0, 8'hDA);
    wait_edges(0, 7);
    tx_r[0] = 8'hFF;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_done(0, 1'b0);
    repeat (80) @(negedge clk);
    check_int("single_done", 0, done_cnt[0] - dc, 1);
    check8("ignored_start_rx", 0, rx_w[0], 8'hDA);
    check8("ignored_start_slave", 0, s_last[0], 8'h36);
    $display("busy start: done pulses %0d slave %02h", done_cnt[0] - dc, s_last[0]);

    // Reset at the 10th sclk edge aborts the transfer.
    dc = done_cnt[0];
    start_xfer(0, 8'h36, 2'd0, 8'h77);
    wait_edges(0, 9);
    rst_r[0] = 1'b1;
    @(negedge clk);
    rst_r[0] = 1'b0;
    check1("abort_ss", 0, ss_w[0], 1'b1);
    check1("abort_sclk", 0, sclk_w[0], 1'b0);
    check1("abort_busy", 0, busy_w[0], 1'b0);
    check8("abort_rx", 0, rx_w[0], 8'h00);
    repeat (80) @(negedge clk);
    check_int("abort_no_done", 0, done_cnt[0] - dc, 0);
    start_xfer(0, 8'h36, 2'd0, 8'hDA);
    wait_done(0, 1'b0);
    check8("after_abort_rx", 0, rx_w[0], 8'hDA);
    $display("abort: rx after restart %02h", rx_w[0]);

    // A mode change mid-transfer does not affect it; the idle sclk follows it.
    start_xfer(0, 8'h36, 2'd0, 8'hDA);
    wait_edges(0, 5);
    mode_r[0] = 2'd3;
    wait_done(0, 1'b0);
    check8("mode_chg_rx", 0, rx_w[0], 8'hDA);
    @(negedge clk);
    check8("mode_chg_slave", 0, s_last[0], 8'h36);
    check1("mode_chg_idle_hi", 0, sclk_w[0], 1'b1);
    mode_r[0] = 2'd0;
    @(negedge clk);
    check1("mode_chg_idle_lo", 0, sclk_w[0], 1'b0);
    $display("mode change: rx %02h slave %02h", rx_w[0], s_last[0]);

    // Randomized transfers with noise on the inputs while busy.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 2; i++) begin
        repeat ($urandom_range(0, 4)) begin
          mode_r[i] = 2'($urandom);
          @(negedge clk);
        end
        start_xfer(i, 8'($urandom), 2'($urandom), 8'($urandom));
        wait_done(i, 1'b1);
        $display("random %0d dut%0d: mode %0d tx %02h rx %02h", it, i, m_mode[i], m_tx[i], rx_w[i]);
        @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
